commit_unit: RTL and testbench
==============================

# commit_unit

In-order retirement stage sitting at the head of the reorder buffer. It checks the ROB head entry each cycle and retires it once it is finished. Retiring means popping the entry, updating the architectural rename state, freeing the old physical register, releasing committed stores to the store buffer and sending branch outcomes to the predictor. On a mispredicted branch it retires that branch, redirects fetch and drives a multi-cycle pipeline flush.

## Interface
Parameters:
- PHY_WIDTH, 6, physical register index width
- STORE_ID_WIDTH, 4, store buffer id width
- ADDR_WIDTH, 32, PC width
- FLUSH_CYCLES, 2, cycles `flush` stays high after a mispredict (min 1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- head_entry  in  ROB_ENTRY_t  ROB entry at head (rd_arch, rd_phy_old, rd_phy_new, opcode, mispredict, actual_taken, actual_target, update_pc, store_id, valid)
- head_finish  in  1  finish bit of head entry
- rob_empty  in  1  ROB holds no entries
- commit_pop  out  1  head retired this cycle; ROB advances head
- retire_valid  out  1  architectural map update
- retire_rd_arch  out  5  architectural destination
- retire_rd_phy  out  PHY_WIDTH  new mapping (head_entry.rd_phy_new)
- free_valid  out  1  return a register to the free list
- free_phy  out  PHY_WIDTH  head_entry.rd_phy_old
- store_commit_valid  out  1  request to drain a store
- store_commit_id  out  STORE_ID_WIDTH  head_entry.store_id
- store_commit_ready  in  1  store buffer accepts the request
- bp_update_valid, bp_update_pc, bp_actual_target, bp_actual_taken  out  1/ADDR_WIDTH/ADDR_WIDTH/1  predictor update
- redirect_valid  out  1  fetch redirect, one-cycle pulse
- redirect_pc  out  ADDR_WIDTH  correct fetch PC
- flush  out  1  squash front end, ROB and issue queues
- retired_count  out  32  total retired instructions

## Operation
- Retirement candidate = !rob_empty && head_entry.valid && head_finish, evaluated only in state RUN.
- Opcode classes (RISC-V): STORE = 7'b0100011; BRANCH = 7'b1100011; JAL = 7'b1101111; JALR = 7'b1100111. Control = BRANCH, JAL or JALR.
- Non-store candidate in RUN:
  - commit_pop = 1.
  - retire_valid = free_valid = (rd_arch != 0).
  - If control: bp_update_valid = 1, with update_pc, actual_target and actual_taken taken from the entry.
- Store candidate in RUN:
  - store_commit_valid = 1.
  - If store_commit_ready is high that cycle: commit_pop = 1, stay in RUN.
  - Otherwise go to STORE_WAIT.
- STORE_WAIT:
  - store_commit_valid stays 1 and store_commit_id stays stable.
  - When store_commit_ready is seen: commit_pop = 1, return to RUN.
  - Stores never assert retire_valid or free_valid.
- Mispredict (control candidate with head_entry.mispredict = 1):
  - Retires normally: pop, rename/free if rd_arch != 0, bp update.
  - Also redirect_valid = 1 with redirect_pc = actual_taken ? actual_target : update_pc + 4, truncated to ADDR_WIDTH.
  - Next state is FLUSH.
- FLUSH:
  - flush = 1 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter, then RUN.
  - No pops and no retire, free, store or bp outputs during FLUSH.
- retired_count increments by 1 on every commit_pop, wrapping modulo 2^32.
- At most one retirement per cycle.

## Timing
- Reset: state RUN, flush counter 0, retired_count 0. Every output is 0.
- Reset asserted mid-STORE_WAIT or mid-FLUSH: immediate return to RUN with all outputs 0. No pending store is replayed.
- Latency:
  - commit_pop, retire, free, store_commit_valid, bp and redirect outputs are combinational from head inputs and state.
  - A finished head retires in the same cycle it becomes finished.
- flush is registered: it rises the cycle after the redirect_valid pulse and falls after FLUSH_CYCLES cycles.
- Store handshake: transfer happens in a cycle with valid && ready. valid never deasserts before that transfer.
- Empty ROB, or unfinished head: all strobes 0, no state change.
- A head with valid = 0 is ignored and never popped.
- A store with mispredict set is treated as a plain store; the mispredict bit is ignored.

## Test plan
- ALU op (rd_arch=5, rd_phy_old=12, rd_phy_new=33), finished -> same cycle: commit_pop, retire (5→33), free 12; retired_count goes 0→1.
- Op with rd_arch=0 finished -> commit_pop=1, retire_valid=0, free_valid=0.
- Store (store_id=7) finished, ready held low for 3 cycles then high -> store_commit_valid high with id 7 for 4 cycles; single commit_pop in the 4th cycle.
- BRANCH mispredict with actual_taken=0, update_pc=0x100 -> redirect_pc=0x104 for one cycle; flush high for the next 2 cycles; no pop during flush even with a finished head.
- JAL mispredict with taken=1, target=0x2000, rd_arch=1 -> retire x1, redirect 0x2000, bp_update_valid=1.
- Reset asserted during STORE_WAIT and during the flush window -> next cycle all outputs 0 and state RUN; retired_count reads 0.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage at the head of the reorder buffer.
// Retires a finished head each cycle: pops the ROB, updates the architectural
// map, frees the old physical register, drains committed stores through a
// valid/ready handshake, sends branch outcomes to the predictor, and on a
// mispredict redirects fetch and holds a registered flush for FLUSH_CYCLES.
// Ports:
//   clk, rst                      clock, async active-high reset
//   head_entry, head_finish       ROB head entry and its finish bit
//   rob_empty                     ROB holds no entries
//   commit_pop                    head retired this cycle
//   retire_valid/rd_arch/rd_phy   architectural map update
//   free_valid/free_phy           register returned to the free list
//   store_commit_valid/id/ready   store drain handshake
//   bp_update_*                   predictor update
//   redirect_valid/redirect_pc    one-cycle fetch redirect
//   flush                         registered pipeline squash
//   retired_count                 total retired instructions (wraps)

package commit_unit_pkg;
  localparam int unsigned ARCH_W     = 5;
  localparam int unsigned PHY_W      = 6;
  localparam int unsigned STORE_ID_W = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned OPC_W      = 7;

  typedef struct packed {
    logic [ARCH_W-1:0]     rd_arch;
    logic [PHY_W-1:0]      rd_phy_old;
    logic [PHY_W-1:0]      rd_phy_new;
    logic [OPC_W-1:0]      opcode;
    logic                  mispredict;
    logic                  actual_taken;
    logic [ADDR_W-1:0]     actual_target;
    logic [ADDR_W-1:0]     update_pc;
    logic [STORE_ID_W-1:0] store_id;
    logic                  valid;
  } rob_entry_t;
endpackage

module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned PHY_WIDTH      = commit_unit_pkg::PHY_W,
  parameter int unsigned STORE_ID_WIDTH = commit_unit_pkg::STORE_ID_W,
  parameter int unsigned ADDR_WIDTH     = commit_unit_pkg::ADDR_W,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  rob_entry_t                head_entry,
  input  logic                      head_finish,
  input  logic                      rob_empty,
  output logic                      commit_pop,
  output logic                      retire_valid,
  output logic [4:0]                retire_rd_arch,
  output logic [PHY_WIDTH-1:0]      retire_rd_phy,
  output logic                      free_valid,
  output logic [PHY_WIDTH-1:0]      free_phy,
  output logic                      store_commit_valid,
  output logic [STORE_ID_WIDTH-1:0] store_commit_id,
  input  logic                      store_commit_ready,
  output logic                      bp_update_valid,
  output logic [ADDR_WIDTH-1:0]     bp_update_pc,
  output logic [ADDR_WIDTH-1:0]     bp_actual_target,
  output logic                      bp_actual_taken,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      flush,
  output logic [31:0]               retired_count
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

  state_t                    state, next_state;
  logic [CNT_W-1:0]          flush_cnt, next_cnt;
  logic [STORE_ID_WIDTH-1:0] store_id_q, next_sid;

  logic candidate, is_store, is_ctrl, has_rd;

  assign candidate = !rob_empty && head_entry.valid && head_finish;
  assign is_store  = (head_entry.opcode == OP_STORE);
  assign is_ctrl   = (head_entry.opcode == OP_BRANCH) || (head_entry.opcode == OP_JAL) ||
                     (head_entry.opcode == OP_JALR);
  assign has_rd    = (head_entry.rd_arch != 5'd0);

  // State register, flush counter, latched store id, flush and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      flush_cnt     <= '0;
      store_id_q    <= '0;
      flush         <= 1'b0;
      retired_count <= 32'd0;
    end else begin
      state      <= next_state;
      flush_cnt  <= next_cnt;
      store_id_q <= next_sid;
      flush      <= (next_state == FLUSH);
      if (commit_pop) retired_count <= retired_count + 32'd1;
    end
  end

  // Next state and combinational retirement strobes; forced quiet during reset
  always_comb begin
    next_state         = state;
    next_cnt           = flush_cnt;
    next_sid           = store_id_q;
    commit_pop         = 1'b0;
    retire_valid       = 1'b0;
    retire_rd_arch     = 5'd0;
    retire_rd_phy      = '0;
    free_valid         = 1'b0;
    free_phy           = '0;
    store_commit_valid = 1'b0;
    store_commit_id    = '0;
    bp_update_valid    = 1'b0;
    bp_update_pc       = '0;
    bp_actual_target   = '0;
    bp_actual_taken    = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          if (candidate) begin
            if (is_store) begin
              // Mispredict bit is meaningless on a store and is ignored
              store_commit_valid = 1'b1;
              store_commit_id    = STORE_ID_WIDTH'(head_entry.store_id);
              if (store_commit_ready) begin
                commit_pop = 1'b1;
              end else begin
                next_state = STORE_WAIT;
                next_sid   = STORE_ID_WIDTH'(head_entry.store_id);
              end
            end else begin
              commit_pop = 1'b1;
              if (has_rd) begin
                retire_valid   = 1'b1;
                retire_rd_arch = head_entry.rd_arch;
                retire_rd_phy  = PHY_WIDTH'(head_entry.rd_phy_new);
                free_valid     = 1'b1;
                free_phy       = PHY_WIDTH'(head_entry.rd_phy_old);
              end
              if (is_ctrl) begin
                bp_update_valid  = 1'b1;
                bp_update_pc     = ADDR_WIDTH'(head_entry.update_pc);
                bp_actual_target = ADDR_WIDTH'(head_entry.actual_target);
                bp_actual_taken  = head_entry.actual_taken;
                if (head_entry.mispredict) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = head_entry.actual_taken ?
                                   ADDR_WIDTH'(head_entry.actual_target) :
                                   ADDR_WIDTH'(head_entry.update_pc + 32'd4);
                  next_state     = FLUSH;
                  next_cnt       = CNT_W'(FLUSH_CYCLES);
                end
              end
            end
          end
        end
        STORE_WAIT: begin
          // Hold the request with the latched id until the buffer accepts it
          store_commit_valid = 1'b1;
          store_commit_id    = store_id_q;
          if (store_commit_ready) begin
            commit_pop = 1'b1;
            next_state = RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt <= CNT_W'(1)) begin
            next_state = RUN;
            next_cnt   = '0;
          end else begin
            next_cnt = flush_cnt - CNT_W'(1);
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit. Inputs change 1ns after the
// rising edge; outputs are checked on the falling edge.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst;
  rob_entry_t  head_entry;
  logic        head_finish, rob_empty, store_commit_ready;
  logic        commit_pop, retire_valid, free_valid, store_commit_valid;
  logic [4:0]  retire_rd_arch;
  logic [5:0]  retire_rd_phy, free_phy;
  logic [3:0]  store_commit_id;
  logic        bp_update_valid, bp_actual_taken, redirect_valid, flush;
  logic [31:0] bp_update_pc, bp_actual_target, redirect_pc, retired_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk(clk), .rst(rst), .head_entry(head_entry), .head_finish(head_finish),
    .rob_empty(rob_empty), .commit_pop(commit_pop), .retire_valid(retire_valid),
    .retire_rd_arch(retire_rd_arch), .retire_rd_phy(retire_rd_phy),
    .free_valid(free_valid), .free_phy(free_phy),
    .store_commit_valid(store_commit_valid), .store_commit_id(store_commit_id),
    .store_commit_ready(store_commit_ready), .bp_update_valid(bp_update_valid),
    .bp_update_pc(bp_update_pc), .bp_actual_target(bp_actual_target),
    .bp_actual_taken(bp_actual_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .retired_count(retired_count)
  );

  function automatic rob_entry_t mk(input logic [4:0] rd, input logic [5:0] old_p,
                                    input logic [5:0] new_p, input logic [6:0] opc,
                                    input logic mis, input logic tkn,
                                    input logic [31:0] tgt, input logic [31:0] pc,
                                    input logic [3:0] sid);
    rob_entry_t e;
    e.rd_arch       = rd;
    e.rd_phy_old    = old_p;
    e.rd_phy_new    = new_p;
    e.opcode        = opc;
    e.mispredict    = mis;
    e.actual_taken  = tkn;
    e.actual_target = tgt;
    e.update_pc     = pc;
    e.store_id      = sid;
    e.valid         = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a finished head present: every output must stay 0
    rst = 1'b1;
    head_entry = mk(5'd5, 6'd12, 6'd33, OP_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    head_finish = 1'b1; rob_empty = 1'b0; store_commit_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pop", 32'(commit_pop), 0);
    chk("rst_retire", 32'(retire_valid), 0);
    chk("rst_free", 32'(free_valid), 0);
    chk("rst_store", 32'(store_commit_valid), 0);
    chk("rst_bp", 32'(bp_update_valid), 0);
    chk("rst_redirect", 32'(redirect_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_count", retired_count, 0);

    // ALU op retires in the same cycle
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("alu_pop", 32'(commit_pop), 1);
    chk("alu_retire", 32'(retire_valid), 1);
    chk("alu_rd_arch", 32'(retire_rd_arch), 5);
    chk("alu_rd_phy", 32'(retire_rd_phy), 33);
    chk("alu_free", 32'(free_valid), 1);
    chk("alu_free_phy", 32'(free_phy), 12);
    chk("alu_count_before", retired_count, 0);

    tick(); rob_empty = 1'b1;
    @(negedge clk);
    chk("empty_pop", 32'(commit_pop), 0);
    chk("empty_retire", 32'(retire_valid), 0);
    chk("alu_count_after", retired_count, 1);

    // rd_arch = 0: pop without rename/free
    tick(); rob_empty = 1'b0;
    head_entry = mk(5'd0, 6'd3, 6'd4, OP_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    chk("x0_pop", 32'(commit_pop), 1);
    chk("x0_retire", 32'(retire_valid), 0);
    chk("x0_free", 32'(free_valid), 0);

    // Store id 7 with ready low for 3 cycles, then high
    tick();
    head_entry = mk(5'd6, 6'd1, 6'd2, OP_ST, 1'b0, 1'b0, 32'h0, 32'h0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      @(negedge clk);
      chk("st_wait_valid", 32'(store_commit_valid), 1);
      chk("st_wait_id", 32'(store_commit_id), 7);
      chk("st_wait_pop", 32'(commit_pop), 0);
      chk("st_wait_retire", 32'(retire_valid), 0);
    end
    tick(); store_commit_ready = 1'b1;
    @(negedge clk);
    chk("st_xfer_valid", 32'(store_commit_valid), 1);
    chk("st_xfer_id", 32'(store_commit_id), 7);
    chk("st_xfer_pop", 32'(commit_pop), 1);
    chk("st_xfer_free", 32'(free_valid), 0);
    chk("st_count", retired_count, 2);

    // Correctly predicted branch: bp update, no redirect
    tick(); store_commit_ready = 1'b0;
    head_entry = mk(5'd0, 6'd0, 6'd0, OP_BR, 1'b0, 1'b1, 32'h300, 32'h200, 4'd0);
    @(negedge clk);
    chk("br_pop", 32'(commit_pop), 1);
    chk("br_store", 32'(store_commit_valid), 0);
    chk("br_bp", 32'(bp_update_valid), 1);
    chk("br_bp_pc", bp_update_pc, 32'h200);
    chk("br_bp_tgt", bp_actual_target, 32'h300);
    chk("br_bp_taken", 32'(bp_actual_taken), 1);
    chk("br_redirect", 32'(redirect_valid), 0);
    chk("br_count", retired_count, 3);

    // Store carrying a mispredict bit is a plain store
    tick(); store_commit_ready = 1'b1;
    head_entry = mk(5'd0, 6'd0, 6'd0, OP_ST, 1'b1, 1'b1, 32'h900, 32'h800, 4'd3);
    @(negedge clk);
    chk("stm_pop", 32'(commit_pop), 1);
    chk("stm_id", 32'(store_commit_id), 3);
    chk("stm_redirect", 32'(redirect_valid), 0);
    chk("stm_bp", 32'(bp_update_valid), 0);
    chk("br_no_flush", 32'(flush), 0);

    // Branch mispredict, not taken, pc 0x100 -> redirect 0x104
    tick(); store_commit_ready = 1'b0;
    head_entry = mk(5'd0, 6'd0, 6'd0, OP_BR, 1'b1, 1'b0, 32'h500, 32'h100, 4'd0);
    @(negedge clk);
    chk("stm_no_flush", 32'(flush), 0);
    chk("mp_pop", 32'(commit_pop), 1);
    chk("mp_redirect", 32'(redirect_valid), 1);
    chk("mp_redirect_pc", redirect_pc, 32'h104);
    chk("mp_bp", 32'(bp_update_valid), 1);
    chk("mp_bp_taken", 32'(bp_actual_taken), 0);
    chk("mp_count", retired_count, 5);

    tick();
    head_entry = mk(5'd7, 6'd20, 6'd21, OP_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    chk("fl1_flush", 32'(flush), 1);
    chk("fl1_pop", 32'(commit_pop), 0);
    chk("fl1_redirect", 32'(redirect_valid), 0);
    chk("fl1_retire", 32'(retire_valid), 0);
    tick();
    @(negedge clk);
    chk("fl2_flush", 32'(flush), 1);
    chk("fl2_pop", 32'(commit_pop), 0);
    chk("fl2_bp", 32'(bp_update_valid), 0);
    tick();
    @(negedge clk);
    chk("fl_end_flush", 32'(flush), 0);
    chk("fl_end_pop", 32'(commit_pop), 1);
    chk("fl_end_rd", 32'(retire_rd_arch), 7);
    chk("fl_end_count", retired_count, 6);

    // JAL mispredict, taken to 0x2000, writes x1
    tick();
    head_entry = mk(5'd1, 6'd2, 6'd40, OP_JAL, 1'b1, 1'b1, 32'h2000, 32'h1000, 4'd0);
    @(negedge clk);
    chk("jal_pop", 32'(commit_pop), 1);
    chk("jal_retire", 32'(retire_valid), 1);
    chk("jal_rd_arch", 32'(retire_rd_arch), 1);
    chk("jal_rd_phy", 32'(retire_rd_phy), 40);
    chk("jal_free_phy", 32'(free_phy), 2);
    chk("jal_redirect", 32'(redirect_valid), 1);
    chk("jal_redirect_pc", redirect_pc, 32'h2000);
    chk("jal_bp", 32'(bp_update_valid), 1);
    chk("jal_bp_taken", 32'(bp_actual_taken), 1);

    tick();
    head_entry = mk(5'd9, 6'd10, 6'd11, OP_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    chk("jal_flush", 32'(flush), 1);
    chk("jal_count", retired_count, 8);

    // Reset in the middle of the flush window
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("rfl_flush", 32'(flush), 0);
    chk("rfl_pop", 32'(commit_pop), 0);
    chk("rfl_count", retired_count, 0);
    tick(); rst = 1'b0; rob_empty = 1'b1;
    @(negedge clk);
    chk("rfl_after_flush", 32'(flush), 0);
    tick();
    @(negedge clk);
    chk("rfl_after_flush2", 32'(flush), 0);

    // Reset during STORE_WAIT: no replay afterwards
    tick(); rob_empty = 1'b0;
    head_entry = mk(5'd0, 6'd0, 6'd0, OP_ST, 1'b0, 1'b0, 32'h0, 32'h0, 4'd5);
    @(negedge clk);
    chk("rsw_valid0", 32'(store_commit_valid), 1);
    tick();
    @(negedge clk);
    chk("rsw_valid1", 32'(store_commit_valid), 1);
    chk("rsw_pop1", 32'(commit_pop), 0);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("rsw_rst_valid", 32'(store_commit_valid), 0);
    chk("rsw_rst_pop", 32'(commit_pop), 0);
    tick(); rst = 1'b0; store_commit_ready = 1'b1;
    head_entry = mk(5'd5, 6'd12, 6'd33, OP_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    chk("rsw_no_replay", 32'(store_commit_valid), 0);
    chk("rsw_run_pop", 32'(commit_pop), 1);
    chk("rsw_run_retire", 32'(retire_valid), 1);
    chk("rsw_count0", retired_count, 0);
    tick(); rob_empty = 1'b1;
    @(negedge clk);
    chk("rsw_count1", retired_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
